hazard_scoreboard: RTL and testbench

- Producer-side companion to the EX-stage forwarding logic; handles the hazards that forwarding cannot resolve.
- Tracks destination registers of issued long-latency instructions (loads, future multi-cycle ops) until their writeback.
- Stalls the ID stage when an instruction reads, or rewrites, a register whose result is not yet available.
- Sits between decode/issue and the writeback port; also keeps an occupancy count and a stall performance counter.

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-file geometry and hazard classification.
// hazard_cause_e is a debug view of why ID is being held.
package pipeline_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_RAW,
        HZ_WAW,
        HZ_CAP
    } hazard_cause_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear is available alongside the asynchronous reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of in-flight long-latency writes and holds ID
// on RAW, WAW or scoreboard-full hazards that forwarding cannot cover.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic [REG_ADDR_W-1:0]            id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]            id_rs2_addr,
    input  logic                             id_uses_rs1,
    input  logic                             id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]            id_rd_addr,
    input  logic                             id_reg_write,
    input  logic                             id_long_lat,
    input  logic                             id_flush,
    input  logic                             wb_valid,
    input  logic [REG_ADDR_W-1:0]            wb_rd_addr,
    output logic                             stall,
    output logic [NUM_REGS-1:0]              pending,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
    output logic [CNT_W-1:0]                 stall_cycles,
    output logic                             err_spurious
);

    localparam int CW = $clog2(MAX_PENDING + 1);

    logic [NUM_REGS-1:0] pending_q;
    logic [CW-1:0]       cnt_q;
    logic                err_q;
    hazard_cause_e       cause;
    logic                raw_hz;
    logic                waw_hz;
    logic                cap_hz;
    logic                issue;
    logic                set_en;
    logic                clr_en;

    // pending_q[0] is never set because set_en excludes rd==0.
    assign raw_hz = (id_uses_rs1 && pending_q[id_rs1_addr]) ||
                    (id_uses_rs2 && pending_q[id_rs2_addr]);
    assign waw_hz = id_reg_write && pending_q[id_rd_addr];
    assign cap_hz = id_long_lat && id_reg_write && (id_rd_addr != '0) &&
                    (cnt_q == CW'(MAX_PENDING));

    always_comb begin
        cause = HZ_NONE;
        if (id_valid && !id_flush) begin
            if (raw_hz) begin
                cause = HZ_RAW;
            end else if (waw_hz) begin
                cause = HZ_WAW;
            end else if (cap_hz) begin
                cause = HZ_CAP;
            end
        end
    end

    assign stall  = (cause != HZ_NONE);
    assign issue  = id_valid && !id_flush && !stall;
    assign set_en = issue && id_long_lat && id_reg_write && (id_rd_addr != '0);
    assign clr_en = wb_valid && (wb_rd_addr != '0) && pending_q[wb_rd_addr];

    // Set is applied after clear so a forced same-register collision keeps the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (clr_en) begin
                pending_q[wb_rd_addr] <= 1'b0;
            end
            if (set_en) begin
                pending_q[id_rd_addr] <= 1'b1;
            end
            if (set_en && !clr_en) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (clr_en && !set_en) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (wb_valid && !clr_en) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pending      = pending_q;
    assign pending_cnt  = cnt_q;
    assign err_spurious = err_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .clr   (1'b0),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a register-level reference model checked
// every cycle, plus hand-computed checkpoints through each scenario.
module tb_hazard_scoreboard;

    localparam int MAX_PENDING = 4;
    localparam int CNT_W       = 32;
    localparam int CW          = $clog2(MAX_PENDING + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1_addr = '0;
    logic [4:0]       id_rs2_addr = '0;
    logic             id_uses_rs1 = 1'b0;
    logic             id_uses_rs2 = 1'b0;
    logic [4:0]       id_rd_addr = '0;
    logic             id_reg_write = 1'b0;
    logic             id_long_lat = 1'b0;
    logic             id_flush = 1'b0;
    logic             wb_valid = 1'b0;
    logic [4:0]       wb_rd_addr = '0;
    logic             stall;
    logic [31:0]      pending;
    logic [CW-1:0]    pending_cnt;
    logic [CNT_W-1:0] stall_cycles;
    logic             err_spurious;

    int n_vec = 0;
    int n_bad = 0;

    bit     m_pend [32];
    bit     m_err;
    longint m_stalls;

    hazard_scoreboard #(
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .id_long_lat  (id_long_lat),
        .id_flush     (id_flush),
        .wb_valid     (wb_valid),
        .wb_rd_addr   (wb_rd_addr),
        .stall        (stall),
        .pending      (pending),
        .pending_cnt  (pending_cnt),
        .stall_cycles (stall_cycles),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit model_stall();
        if (!id_valid || id_flush) return 1'b0;
        if (id_uses_rs1 && m_pend[id_rs1_addr]) return 1'b1;
        if (id_uses_rs2 && m_pend[id_rs2_addr]) return 1'b1;
        if (id_reg_write && m_pend[id_rd_addr]) return 1'b1;
        if (id_long_lat && id_reg_write && id_rd_addr != 0 && model_count() == MAX_PENDING)
            return 1'b1;
        return 1'b0;
    endfunction

    task automatic compareField(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare outputs mid-cycle, then advance to the next edge's state.
    always @(negedge clk) begin
        bit es;
        bit do_set;
        bit do_clr;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            m_err    = 1'b0;
            m_stalls = 0;
        end else begin
            es = model_stall();
            compareField("model.stall", longint'(stall), longint'(es));
            compareField("model.pending", longint'(pending), longint'(model_vec()));
            compareField("model.pending_cnt", longint'(pending_cnt), longint'(model_count()));
            compareField("model.stall_cycles", longint'(stall_cycles), m_stalls);
            compareField("model.err_spurious", longint'(err_spurious), longint'(m_err));
            do_set = id_valid && !id_flush && !es && id_long_lat && id_reg_write && id_rd_addr != 0;
            do_clr = wb_valid && wb_rd_addr != 0 && m_pend[wb_rd_addr];
            if (wb_valid && !do_clr) m_err = 1'b1;
            if (do_clr) m_pend[wb_rd_addr] = 1'b0;
            if (do_set) m_pend[id_rd_addr] = 1'b1;
            if (es && m_stalls != 64'hFFFF_FFFF) m_stalls++;
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic rw, input logic ll, input logic fl,
                                 input logic wbv, input logic [4:0] wbrd);
        @(posedge clk);
        #1;
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_uses_rs1  = u1;
        id_rs2_addr  = rs2;
        id_uses_rs2  = u2;
        id_rd_addr   = rd;
        id_reg_write = rw;
        id_long_lat  = ll;
        id_flush     = fl;
        wb_valid     = wbv;
        wb_rd_addr   = wbrd;
    endtask

    task automatic sampleMid();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic exp_stall, input logic [31:0] exp_pend,
                               input int exp_cnt, input longint exp_sc, input logic exp_err);
        compareField({name, ".stall"}, longint'(stall), longint'(exp_stall));
        compareField({name, ".pending"}, longint'(pending), longint'(exp_pend));
        compareField({name, ".pending_cnt"}, longint'(pending_cnt), longint'(exp_cnt));
        compareField({name, ".stall_cycles"}, longint'(stall_cycles), exp_sc);
        compareField({name, ".err_spurious"}, longint'(err_spurious), longint'(exp_err));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Load-use: load x5 then add x6,x5,x7 held until wb of x5
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("ld_x5", 0, 32'h0, 0, 0, 0);
        applyStimulus(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0);
        sampleMid(); checkOutput("use_stall", 1, 32'h20, 1, 0, 0);
        applyStimulus(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0);
        sampleMid(); checkOutput("use_hold", 1, 32'h20, 1, 1, 0);
        applyStimulus(1, 5, 1, 7, 1, 6, 1, 0, 0, 1, 5);
        sampleMid(); checkOutput("use_wb", 1, 32'h20, 1, 2, 0);
        applyStimulus(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0);
        sampleMid(); checkOutput("use_release", 0, 32'h0, 0, 3, 0);

        // x0 is never tracked; a wb to x0 is spurious
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("ld_x0", 0, 32'h0, 0, 3, 0);
        applyStimulus(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        sampleMid(); checkOutput("use_x0", 0, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        sampleMid(); checkOutput("wb_x0", 0, 32'h0, 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("err_sticky", 0, 32'h0, 0, 3, 1);

        // Capacity: x1..x4 fill the scoreboard, x9 waits for a free slot
        for (int r = 1; r <= 4; r++) applyStimulus(1, 0, 0, 0, 0, 5'(r), 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("cap_stall", 1, 32'h1E, 4, 3, 1);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 2);
        sampleMid(); checkOutput("cap_wb", 1, 32'h1E, 4, 4, 1);
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("cap_issue", 0, 32'h1A, 3, 5, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("cap_after", 0, 32'h21A, 4, 5, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("drained", 0, 32'h0, 0, 5, 1);

        // WAW on x8 released by a same-cycle wb, then set/clear of different regs
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 1, 8);
        sampleMid(); checkOutput("waw_stall", 1, 32'h100, 1, 5, 1);
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("waw_issue", 0, 32'h0, 0, 6, 1);
        applyStimulus(1, 0, 0, 0, 0, 10, 1, 1, 0, 1, 8);
        sampleMid(); checkOutput("set_clr_diff", 0, 32'h100, 1, 6, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("set_clr_after", 0, 32'h400, 1, 6, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10);

        // Flush hides a RAW on x3 and blocks the flushed load from issuing
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 3, 1, 12, 1, 1, 1, 0, 0);
        sampleMid(); checkOutput("flush", 0, 32'h8, 1, 6, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("flush_after", 0, 32'h8, 1, 6, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("flush_wb", 0, 32'h0, 0, 6, 1);

        // Asynchronous reset in the middle of a stall
        for (int r = 1; r <= 3; r++) applyStimulus(1, 0, 0, 0, 0, 5'(r), 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        sampleMid(); checkOutput("pre_reset", 1, 32'hE, 3, 6, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("mid_reset", 0, 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        sampleMid(); checkOutput("post_reset", 0, 32'h0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sampleMid(); checkOutput("post_reset_ld", 0, 32'h80, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
